// File: rtl/hilo_muldiv_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Opcodes match the decode aluop encodings one-for-one.
// Pure declarations: no latency, no backpressure.
package hilo_muldiv_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  localparam logic [5:0] MULT_OP = 6'b000010;
  localparam logic [5:0] DIV_OP  = 6'b000011;
  localparam logic [5:0] MFHI_OP = 6'b000100;
  localparam logic [5:0] MFLO_OP = 6'b000101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  function automatic logic is_muldiv_op(input logic [5:0] op);
    return (op == MULT_OP) || (op == DIV_OP);
  endfunction

  function automatic logic is_hilo_op(input logic [5:0] op);
    return (op == MULT_OP) || (op == DIV_OP) || (op == MFHI_OP) || (op == MFLO_OP);
  endfunction

endpackage

// File: rtl/hilo_muldiv_seq_step.sv
// One iteration of shift-add multiply or restoring divide on a {upper, lower} accumulator.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the result is registered.
module hilo_muldiv_seq_step
  import hilo_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [WIDTH-1:0]   acc_nxt,
  output logic [WIDTH-1:0]   bits_nxt
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  always_comb begin
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    rem_ge    = rem_shift >= {1'b0, operand};
    // The difference is always below 2**WIDTH when rem_ge holds, so modular subtraction is exact.
    rem_sub   = rem_shift[WIDTH-1:0] - operand;
    if (is_div) begin
      acc_nxt  = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
      bits_nxt = {acc[WIDTH-2:0], rem_ge};
    end else begin
      acc_nxt  = add_sum[WIDTH:1];
      bits_nxt = {add_sum[0], acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// HI/LO owner: one-bit-per-cycle MULT/MULTU/DIV/DIVU plus MFHI/MFLO reads; MULDIV_EARLY_OUT_EN shortens multiplies.
// Latency: start at E0, hi/lo written and busy low after E33 (multiply may finish early with MULDIV_EARLY_OUT_EN).
// Backpressure: stall is raised combinationally for any muldiv/mf instruction presented while busy.
module hilo_muldiv_seq
  import hilo_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       aluop,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_q, neg_r, b_zero;
  logic               accept, calc_done, last_iter;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign mag_a = (!is_unsigned && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (!is_unsigned && op_b[WIDTH-1]) ? -op_b : op_b;

  hilo_muldiv_seq_step #(.WIDTH(WIDTH)) u_muldiv_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (opnd),
    .acc_nxt  (step_hi),
    .bits_nxt (step_lo)
  );

  assign last_iter = (count == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0] count_inc;
  assign count_inc = count + CNT_W'(1);
  // Low half holds count_inc product bits on top of the unconsumed multiplier bits.
  assign calc_done = last_iter || (!is_div && ((step_lo << count_inc) == '0));
  assign prod_raw  = acc >> (WIDTH - int'(count));
`else
  assign calc_done = last_iter;
  assign prod_raw  = acc;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start && is_muldiv_op(aluop)) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC:    if (calc_done) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    prod_fix = neg_q ? -prod_raw : prod_raw;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      // Divide by zero leaves |a| in the remainder, so the neg_r negation restores the raw dividend.
      fix_lo = (neg_q && !b_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      is_div <= (aluop == DIV_OP);
      neg_q  <= !is_unsigned && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      neg_r  <= !is_unsigned && op_a[WIDTH-1];
      b_zero <= (op_b == '0);
      count  <= '0;
      if (aluop == DIV_OP) begin
        acc  <= {{WIDTH{1'b0}}, mag_a};
        opnd <= mag_b;
      end else begin
        acc  <= {{WIDTH{1'b0}}, mag_b};
        opnd <= mag_a;
      end
    end else if (state == CALC) begin
      acc   <= {step_hi, step_lo};
      count <= count + CNT_W'(1);
    end else if (state == FIXUP) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end
  end

  assign busy  = (state != IDLE);
  assign stall = busy && start && is_hilo_op(aluop);

  always_comb begin
    result = '0;
    if (!busy && start) begin
      if (aluop == MFHI_OP)      result = hi;
      else if (aluop == MFLO_OP) result = lo;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed bench for hilo_muldiv_seq: vector table of muldiv results and latencies, plus
// hand-written sequences for stall/MFLO handoff, ignored starts and mid-operation reset.
module tb_hilo_muldiv_seq;

  localparam logic [5:0] OP_MULT = 6'b000010;
  localparam logic [5:0] OP_DIV  = 6'b000011;
  localparam logic [5:0] OP_MFHI = 6'b000100;
  localparam logic [5:0] OP_MFLO = 6'b000101;
  localparam logic [5:0] OP_ADD  = 6'b100001;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [5:0]  op;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
    int          lat_eo;
  } vec_t;

  logic        clock, reset_n, start, is_unsigned;
  logic [5:0]  aluop;
  logic [31:0] op_a, op_b, result, hi, lo;
  logic        busy, stall;

  int checks = 0;
  int errors = 0;
  vec_t vecs[13];

  hilo_muldiv_seq dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .aluop       (aluop),
    .is_unsigned (is_unsigned),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .stall       (stall),
    .result      (result),
    .hi          (hi),
    .lo          (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach summary (got timeout, required completion)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Issue one muldiv op and count cycles with busy sampled high after each edge.
  task automatic do_op(input logic [5:0] op, input logic uns, input logic [31:0] a,
                       input logic [31:0] b, output int busy_cyc);
    @(negedge clock);
    start = 1'b1; aluop = op; is_unsigned = uns; op_a = a; op_b = b;
    @(posedge clock); #1;
    start = 1'b0; aluop = 6'd0;
    busy_cyc = 0;
    while (busy && busy_cyc < 200) begin
      busy_cyc++;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int cyc;
    int guard;
    int exp_lat;

    vecs[0]  = '{OP_MULT, 1'b0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 33, 3};
    vecs[1]  = '{OP_MULT, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 33};
    vecs[2]  = '{OP_DIV,  1'b1, 32'd7,        32'd2,        32'd1,        32'd3,        33, 33};
    vecs[3]  = '{OP_DIV,  1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33};
    vecs[4]  = '{OP_DIV,  1'b0, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 33, 33};
    vecs[5]  = '{OP_DIV,  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 33};
    vecs[6]  = '{OP_MULT, 1'b0, 32'd5,        32'd1,        32'd0,        32'd5,        33, 2};
    vecs[7]  = '{OP_DIV,  1'b0, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 33, 33};
    vecs[8]  = '{OP_MULT, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'd0,        32'd12,       33, 4};
    vecs[9]  = '{OP_MULT, 1'b1, 32'h80000000, 32'd2,        32'd1,        32'd0,        33, 3};
    vecs[10] = '{OP_DIV,  1'b0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 33};
    vecs[11] = '{OP_MULT, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        33, 33};
    vecs[12] = '{OP_MULT, 1'b0, 32'd1234,     32'd0,        32'd0,        32'd0,        33, 2};

    reset_n = 1'b1; start = 1'b0; aluop = 6'd0; is_unsigned = 1'b0; op_a = '0; op_b = '0;
    #2 reset_n = 1'b0;
    start = 1'b1; aluop = OP_MFHI;
    #1;
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_stall",  {31'd0, stall}, 32'd0);
    check("rst_hi",     hi,             32'd0);
    check("rst_lo",     lo,             32'd0);
    check("rst_result", result,         32'd0);
    start = 1'b0; aluop = 6'd0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].uns, vecs[i].a, vecs[i].b, cyc);
      exp_lat = EARLY ? vecs[i].lat_eo : vecs[i].lat;
      check($sformatf("v%0d_hi", i),  hi,          vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i),  lo,          vecs[i].exp_lo);
      check($sformatf("v%0d_lat", i), 32'(cyc),    32'(exp_lat));
    end

    // MULTU with a re-presented MULT and then MFLO while busy.
    @(negedge clock);
    start = 1'b1; aluop = OP_MULT; is_unsigned = 1'b1; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
    @(negedge clock);
    is_unsigned = 1'b0; op_a = 32'd6; op_b = 32'd7;
    for (int k = 0; k < 2; k++) begin
      #1 check($sformatf("second_mult_stall%0d", k), {31'd0, stall}, 32'd1);
      @(negedge clock);
    end
    start = 1'b0; aluop = 6'd0;
    repeat (2) @(negedge clock);
    guard = 0;
    start = 1'b1; aluop = OP_MFLO;
    #1;
    while (busy && guard < 100) begin
      check("mflo_stall_busy", {31'd0, stall}, 32'd1);
      guard++;
      @(negedge clock); #1;
    end
    check("mflo_busy_fell", {31'd0, busy},  32'd0);
    check("mflo_stall_end", {31'd0, stall}, 32'd0);
    check("mflo_result",    result,         32'h00000001);
    check("hold_hi",        hi,             32'hFFFFFFFE);
    aluop = OP_MFHI;
    #1 check("mfhi_result", result, 32'hFFFFFFFE);
    check("mfhi_stall", {31'd0, stall}, 32'd0);

    // Non-muldiv opcode with start: ignored.
    @(negedge clock);
    aluop = OP_ADD; op_a = 32'd3; op_b = 32'd4;
    #1;
    check("alu_stall",  {31'd0, stall},  32'd0);
    check("alu_result", result,          32'd0);
    @(posedge clock); #1;
    check("alu_busy",   {31'd0, busy},   32'd0);
    check("alu_lo",     lo,              32'h00000001);
    start = 1'b0; aluop = 6'd0;

    // Reset pulse during a divide discards it immediately.
    @(negedge clock);
    start = 1'b1; aluop = OP_DIV; is_unsigned = 1'b0; op_a = 32'd100; op_b = 32'd7;
    @(negedge clock);
    start = 1'b0; aluop = 6'd0;
    repeat (9) @(negedge clock);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_hi",   hi,            32'd0);
    check("mid_rst_lo",   lo,            32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    do_op(OP_MULT, 1'b0, 32'd6, 32'd7, cyc);
    check("post_rst_lo",  lo,       32'd42);
    check("post_rst_hi",  hi,       32'd0);
    check("post_rst_lat", 32'(cyc), EARLY ? 32'd4 : 32'd33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
